// File: rtl/proc_ram_pkg.sv
// Shared types, constants and the program image for the dual-port processor RAM.
// The image is only written into the array when PROC_RAM_PRELOAD_EN is defined.
package proc_ram_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Selects where a port's read data comes from after a request.
  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_MEM,
    SEL_BYP
  } rd_sel_t;

  localparam int IMAGE_LEN = 32;

  localparam logic [7:0] IMAGE [IMAGE_LEN] = '{
    8'h80, 8'h7F, 8'hA4, 8'hC1, 8'hFF, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01
  };

  // Image word at index, zero-extended then masked to data_w bits.
  // Indexes outside the image yield zero.
  function automatic logic [63:0] image_word(input int index, input int data_w);
    logic [63:0] w;
    w = '0;
    if (index >= 0 && index < IMAGE_LEN) begin
      w = {56'b0, IMAGE[index]};
    end
    if (data_w < 64) begin
      w = w & ((64'd1 << data_w) - 64'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/proc_ram_array.sv
// Storage for the processor RAM: one write port and two synchronous read
// ports with registered outputs. Range checking and bypass live in the top.
module proc_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              a_re,
  input  logic [ADDR_W-1:0] a_raddr,
  output logic [DATA_W-1:0] a_q,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_raddr,
  output logic [DATA_W-1:0] b_q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port, shared by the init sequencer and port B.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Instruction-fetch read port; output holds when not enabled.
  always_ff @(posedge clock) begin
    if (a_re) begin
      a_q <= mem[a_raddr];
    end
  end

  // Data read port; output holds when not enabled.
  always_ff @(posedge clock) begin
    if (b_re) begin
      b_q <= mem[b_raddr];
    end
  end

endmodule

// File: rtl/proc_ram_dp.sv
// Dual-port processor RAM: read-only fetch port A and read/write data port B
// over one array. After reset release an init sequencer rewrites every word,
// from the package program image when PROC_RAM_PRELOAD_EN is defined, or with
// zeros otherwise. Ports are ignored until ready rises.
module proc_ram_dp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              ready,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_valid
);

  import proc_ram_pkg::*;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] init_word;

  logic              a_in, b_in;
  logic              a_acc, b_rd, b_wr, a_byp;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] a_mem_q, b_mem_q;
  logic [DATA_W-1:0] a_byp_q;
  rd_sel_t           a_sel, b_sel;

`ifdef PROC_RAM_PRELOAD_EN
  assign init_word = DATA_W'(image_word(int'(cnt), DATA_W));
`else
  assign init_word = '0;
`endif

  assign a_in  = ({1'b0, a_addr} < DEPTH_V);
  assign b_in  = ({1'b0, b_addr} < DEPTH_V);
  assign a_acc = ready & a_en;
  assign b_rd  = ready & b_en & ~b_we;
  assign b_wr  = ready & b_en & b_we;
  // A same-address write on port B wins over the stored word for port A.
  assign a_byp = a_acc & b_wr & a_in & (a_addr == b_addr);

  // Init sequencer: walk every word once after reset, then stay in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            ready <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Write mux: the sequencer owns the write port during INIT, port B after.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = b_addr;
    mem_wdata = b_wdata;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt;
      mem_wdata = init_word;
    end else if (b_wr && b_in) begin
      mem_we = 1'b1;
    end
  end

  proc_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clock   (clock),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .a_re    (a_acc & a_in & ~a_byp),
    .a_raddr (a_addr),
    .a_q     (a_mem_q),
    .b_re    (b_rd & b_in),
    .b_raddr (b_addr),
    .b_q     (b_mem_q)
  );

  // Valid pulses and read-source selection; selections only move on a request
  // so both data outputs hold their last value between requests.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      a_sel   <= SEL_ZERO;
      b_sel   <= SEL_ZERO;
      a_byp_q <= '0;
    end else begin
      a_valid <= a_acc;
      b_valid <= b_rd;
      if (a_acc) begin
        if (a_byp) begin
          a_sel   <= SEL_BYP;
          a_byp_q <= b_wdata;
        end else if (a_in) begin
          a_sel <= SEL_MEM;
        end else begin
          a_sel <= SEL_ZERO;
        end
      end
      if (b_rd) begin
        b_sel <= b_in ? SEL_MEM : SEL_ZERO;
      end
    end
  end

  assign a_data  = (a_sel == SEL_MEM) ? a_mem_q :
                   (a_sel == SEL_BYP) ? a_byp_q : '0;
  assign b_rdata = (b_sel == SEL_MEM) ? b_mem_q : '0;

endmodule

// File: tb/tb_proc_ram_dp.sv
// Scoreboard bench for proc_ram_dp: a 32-word instance and a 20-word instance
// share clock and reset. Expected read data is queued at issue time and popped
// by a monitor whenever a valid pulse appears.
module tb_proc_ram_dp;

  localparam int DW = 8;
  localparam int AW = 5;

  logic clock = 1'b0;
  logic reset;

  logic          ready, a_en, a_valid, b_en, b_we, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_wdata, b_rdata;

  logic          ready20, a_en20, a_valid20, b_en20, b_we20, b_valid20;
  logic [AW-1:0] a_addr20, b_addr20;
  logic [DW-1:0] a_data20, b_wdata20, b_rdata20;

  int compared   = 0;
  int mismatched = 0;
  int e32, e20;

  logic [DW-1:0] qa[$], qb[$], qa20[$], qb20[$];

  int addrs [7] = '{0, 1, 2, 3, 4, 31, 10};

  always #5 clock = ~clock;

  proc_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .a_en(a_en), .a_addr(a_addr), .a_data(a_data), .a_valid(a_valid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_valid(b_valid)
  );

  proc_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(20)) dut20 (
    .clock(clock), .reset(reset), .ready(ready20),
    .a_en(a_en20), .a_addr(a_addr20), .a_data(a_data20), .a_valid(a_valid20),
    .b_en(b_en20), .b_we(b_we20), .b_addr(b_addr20), .b_wdata(b_wdata20),
    .b_rdata(b_rdata20), .b_valid(b_valid20)
  );

  // Hand-written expected image contents after init.
  function automatic logic [7:0] expWord(input int idx);
`ifdef PROC_RAM_PRELOAD_EN
    case (idx)
      0:       return 8'h80;
      1:       return 8'h7F;
      2:       return 8'hA4;
      3:       return 8'hC1;
      4:       return 8'hFF;
      31:      return 8'h01;
      default: return 8'h00;
    endcase
`else
    return 8'h00;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of requests on the selected instance, just after an edge.
  task automatic applyStimulus(input bit sel20, input logic ae, input logic [AW-1:0] aa,
                               input logic be, input logic bw, input logic [AW-1:0] ba,
                               input logic [DW-1:0] bd);
    @(posedge clock);
    #1;
    if (sel20) begin
      a_en20 = ae; a_addr20 = aa; b_en20 = be; b_we20 = bw; b_addr20 = ba; b_wdata20 = bd;
    end else begin
      a_en = ae; a_addr = aa; b_en = be; b_we = bw; b_addr = ba; b_wdata = bd;
    end
  endtask

  task automatic idleBoth();
    @(posedge clock);
    #1;
    a_en = 0; b_en = 0; b_we = 0; a_en20 = 0; b_en20 = 0; b_we20 = 0;
  endtask

  // Counts edges after reset release until each instance raises ready.
  task automatic waitReady(output int c32, output int c20);
    c32 = 0;
    c20 = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (ready && c32 == 0) begin
        c32 = k;
        a_en = 0; b_en = 0; b_we = 0;
      end
      if (ready20 && c20 == 0) c20 = k;
      if (c32 != 0 && c20 != 0) break;
    end
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (a_valid) begin
      if (qa.size() == 0) checkOutput("a_unexpected_valid", 1, 0);
      else checkOutput("a_data", a_data, qa.pop_front());
    end
    if (b_valid) begin
      if (qb.size() == 0) checkOutput("b_unexpected_valid", 1, 0);
      else checkOutput("b_rdata", b_rdata, qb.pop_front());
    end
    if (a_valid20) begin
      if (qa20.size() == 0) checkOutput("a20_unexpected_valid", 1, 0);
      else checkOutput("a20_data", a_data20, qa20.pop_front());
    end
    if (b_valid20) begin
      if (qb20.size() == 0) checkOutput("b20_unexpected_valid", 1, 0);
      else checkOutput("b20_rdata", b_rdata20, qb20.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    a_en20 = 0; a_addr20 = 0; b_en20 = 0; b_we20 = 0; b_addr20 = 0; b_wdata20 = 0;
    // Requests held on the 32-word instance through reset and INIT must be ignored.
    a_en = 1; a_addr = 5'd2; b_en = 1; b_we = 1; b_addr = 5'd2; b_wdata = 8'hEE;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_ready", ready, 0);
    checkOutput("reset_a_data", a_data, 0);
    checkOutput("reset_b_rdata", b_rdata, 0);
    checkOutput("reset_a_valid", a_valid, 0);
    checkOutput("reset_b_valid", b_valid, 0);
    checkOutput("reset_ready20", ready20, 0);

    @(posedge clock);
    #1;
    reset = 1'b1;
    waitReady(e32, e20);
    checkOutput("init_edges_32", e32, 32);
    checkOutput("init_edges_20", e20, 20);

    // Fetch-port reads of the image, back to back.
    foreach (addrs[i]) begin
      applyStimulus(0, 1, AW'(addrs[i]), 0, 0, 0, 0);
      qa.push_back(expWord(addrs[i]));
    end

    // Port B write then read-back.
    applyStimulus(0, 0, 0, 1, 1, 5'd7, 8'h5A);
    applyStimulus(0, 0, 0, 1, 0, 5'd7, 8'h00);
    qb.push_back(8'h5A);

    // Same-cycle collision: port A sees the write data.
    applyStimulus(0, 1, 5'd9, 1, 1, 5'd9, 8'h3C);
    qa.push_back(8'h3C);
    applyStimulus(0, 1, 5'd9, 1, 0, 5'd9, 8'h00);
    qa.push_back(8'h3C);
    qb.push_back(8'h3C);

    idleBoth();
    idleBoth();
    @(negedge clock);
    checkOutput("a_hold", a_data, 8'h3C);
    checkOutput("b_hold", b_rdata, 8'h3C);
    checkOutput("a_valid_idle", a_valid, 0);
    checkOutput("b_valid_idle", b_valid, 0);

    // 20-word instance: out-of-range write dropped, read returns zero.
    applyStimulus(1, 0, 0, 1, 1, 5'd25, 8'h11);
    applyStimulus(1, 1, 5'd25, 1, 0, 5'd25, 8'h00);
    qa20.push_back(8'h00);
    qb20.push_back(8'h00);
    applyStimulus(1, 0, 0, 1, 1, 5'd19, 8'h22);
    applyStimulus(1, 1, 5'd19, 1, 0, 5'd19, 8'h00);
    qa20.push_back(8'h22);
    qb20.push_back(8'h22);
    applyStimulus(1, 1, 5'd20, 1, 1, 5'd20, 8'h33);
    qa20.push_back(8'h00);
    idleBoth();
    idleBoth();

    // Write address 0, read it, then reset mid-RUN.
    applyStimulus(0, 0, 0, 1, 1, 5'd0, 8'h77);
    applyStimulus(0, 1, 5'd0, 0, 0, 0, 0);
    qa.push_back(8'h77);
    idleBoth();
    idleBoth();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("midrun_reset_a_data", a_data, 0);
    checkOutput("midrun_reset_b_rdata", b_rdata, 0);
    checkOutput("midrun_reset_ready", ready, 0);
    checkOutput("midrun_reset_b20_rdata", b_rdata20, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    waitReady(e32, e20);
    checkOutput("reinit_edges_32", e32, 32);
    checkOutput("reinit_edges_20", e20, 20);

    applyStimulus(0, 1, 5'd0, 1, 0, 5'd7, 0);
    qa.push_back(expWord(0));
    qb.push_back(expWord(7));
    idleBoth();
    idleBoth();
    idleBoth();

    checkOutput("qa_drained", qa.size(), 0);
    checkOutput("qb_drained", qb.size(), 0);
    checkOutput("qa20_drained", qa20.size(), 0);
    checkOutput("qb20_drained", qb20.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/proc_ram_dp.md
# proc_ram_dp

Parametrised dual-port processor RAM: a read-only instruction-fetch port A and a read/write data port B share one synchronous array. After reset release, a built-in init sequencer loads the array one word per cycle. The block replaces the single-port 32×8 processor RAM and allows simultaneous instruction fetch and load/store. It sits between the processor control unit and the datapath.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 5, address width in bits
- DEPTH, 32, number of words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_W
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ready  out  1  high once init is complete and ports accept requests
- a_en  in  1  port A read request
- a_addr  in  ADDR_W  port A address
- a_data  out  DATA_W  port A registered read data
- a_valid  out  1  one-cycle pulse: a_data was updated by the previous request
- b_en  in  1  port B request
- b_we  in  1  port B write (1) or read (0); qualified by b_en
- b_addr  in  ADDR_W  port B address
- b_wdata  in  DATA_W  port B write data
- b_rdata  out  DATA_W  port B registered read data
- b_valid  out  1  one-cycle pulse after an accepted port B read

## Operation
- FSM states: INIT, RUN.
- Reset asserted: state=INIT, init counter=0, ready=0, a_data=0, b_rdata=0, a_valid=0, b_valid=0. These take effect asynchronously. Array contents are not reset; INIT rewrites them.
- INIT: each edge writes image word[cnt] to array[cnt] and increments cnt. The edge that writes word DEPTH-1 sets ready=1 and moves to RUN. Port requests during INIT are ignored: no write, no valid, data outputs hold.
- RUN: requests are accepted only when ready=1, which holds in RUN.
- Port A read: a_en=1 → a_data=array[a_addr] at the next edge, and a_valid=1 for that one cycle.
- Port B write: b_en=1 and b_we=1 → array[b_addr]=b_wdata. b_rdata holds and b_valid=0.
- Port B read: b_en=1 and b_we=0 → b_rdata=array[b_addr] and b_valid=1, next cycle.
- Collision: a port A read and a port B write to the same address in the same cycle → a_data returns b_wdata (write-first bypass).
- Out-of-range address (≥ DEPTH): writes are dropped, and reads return 0 with valid still pulsed.
- When no request is made, a_data and b_rdata hold their last values.
- Reset mid-INIT or mid-RUN: the block restarts INIT from word 0. Prior writes are lost to the image.

## Timing
- Init takes exactly DEPTH rising edges after reset deassertion. ready is visible after edge DEPTH.
- Read latency is 1 cycle on both ports. Each port accepts one request per cycle, with no back-pressure.
- A write is visible to a read of the same address on the following cycle. In the same cycle it is visible only through the port A bypass.
- A port B read in the same cycle as a port B write is impossible, because the port carries a single op.

## Configuration
- PROC_RAM_PRELOAD_EN defined: INIT writes the program image from the package.
  - Words 0–4 are 0x80, 0x7F, 0xA4, 0xC1, 0xFF.
  - Word 31 is 0x01.
  - All other words are 0.
  - Image entries at index ≥ DEPTH are skipped. Each word is truncated or zero-extended to DATA_W.
- PROC_RAM_PRELOAD_EN undefined: INIT writes 0 to every word. The INIT duration and ready timing are unchanged.

## Structure
- Package proc_ram_pkg holds:
  - the FSM state enum (INIT, RUN),
  - IMAGE_LEN=32,
  - the image constant array of 8-bit words,
  - an image_word(index, DATA_W) function that returns the zero-extended or truncated value.
- Sub-module proc_ram_array holds the storage: one write port and two synchronous read ports with registered outputs.
- The top level holds the FSM, the init counter, the write mux (init vs port B), the range checks, the bypass and the valid generation.

## Test plan
- Reset, then release with PRELOAD_EN, default parameters → ready rises after exactly 32 edges. Port A reads of addresses 0, 1, 2, 3, 4, 31 return 0x80, 0x7F, 0xA4, 0xC1, 0xFF, 0x01. Address 10 returns 0x00.
- Port B write 0x5A to address 7, then a port B read of address 7 on the next cycle → b_rdata=0x5A and b_valid=1 one cycle later. b_valid=0 during the write cycle.
- Same cycle: port A read of address 9 and port B write of 0x3C to address 9 → a_data=0x3C next cycle.
- Requests during INIT (a_en=1, b_we=1 to address 2 with 0xEE) → no valid pulses. After ready, address 2 reads 0xA4.
- DEPTH=20, ADDR_W=5: write 0x11 to address 25, then read address 25 → b_rdata=0x00 and b_valid=1. Init takes 20 edges.
- Assert reset mid-RUN after writing 0x77 to address 0 → outputs drop to 0 immediately. After re-init, address 0 reads 0x80 with PRELOAD_EN, or 0x00 without it.
